// File: rtl/ita_head_scheduler.sv
// ita_head_scheduler: runs a multi-head attention job one head at a time on the ITA controller.
// Define ITA_HEAD_PERF_CNT_EN to add the per-head cycle counter behind head_cycles_o.
module ita_head_scheduler #(
    parameter int HeadW      = 4,
    parameter int AckTimeout = 16,
    parameter int CycW       = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [HeadW-1:0] num_heads_i,
    input  logic             ita_idle_i,
    output logic             ita_start_o,
    output logic [HeadW-1:0] head_idx_o,
    output logic             head_done_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [CycW-1:0]  head_cycles_o
);
    localparam int AckW = $clog2(AckTimeout + 1);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] WAIT_ACK = 3'd2;
    localparam logic [2:0] RUN      = 3'd3;
    localparam logic [2:0] FINISH   = 3'd4;

    logic [2:0]       state;
    logic [HeadW-1:0] num_heads;
    logic [HeadW-1:0] head_idx;
    logic [AckW-1:0]  ack_cnt;
    logic             head_done;
    logic             done;
    logic             err;

    assign ita_start_o = state == START;
    assign busy_o      = state != IDLE;
    assign head_idx_o  = head_idx;
    assign head_done_o = head_done;
    assign done_o      = done;
    assign err_o       = err;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            num_heads <= '0;
            head_idx  <= '0;
            ack_cnt   <= '0;
            head_done <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            head_done <= 1'b0;
            done      <= 1'b0;
            // abort outranks every transition, including a same-cycle head completion
            if (abort_i && state != IDLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i && num_heads_i != '0) begin
                            num_heads <= num_heads_i;
                            head_idx  <= '0;
                            err       <= 1'b0;
                            state     <= START;
                        end else if (start_i) begin
                            done <= 1'b1;
                        end
                    end
                    START: begin
                        ack_cnt <= '0;
                        state   <= WAIT_ACK;
                    end
                    WAIT_ACK: begin
                        if (!ita_idle_i) begin
                            ack_cnt <= '0;
                            state   <= RUN;
                        end else if (ack_cnt == AckW'(AckTimeout - 1)) begin
                            ack_cnt <= '0;
                            err     <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            ack_cnt <= ack_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (ita_idle_i) begin
                            head_done <= 1'b1;
                            if (head_idx == num_heads - 1'b1) begin
                                done  <= 1'b1;
                                state <= FINISH;
                            end else begin
                                head_idx <= head_idx + 1'b1;
                                state    <= START;
                            end
                        end
                    end
                    FINISH:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef ITA_HEAD_PERF_CNT_EN
    logic [CycW-1:0] cyc_cnt;
    logic [CycW-1:0] cyc_next;
    logic [CycW-1:0] head_cycles;

    // the START cycle counts as 1, the completing idle cycle is included via cyc_next
    assign cyc_next      = &cyc_cnt ? cyc_cnt : cyc_cnt + 1'b1;
    assign head_cycles_o = head_cycles;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cyc_cnt     <= '0;
            head_cycles <= '0;
        end else begin
            if (state == START) begin
                cyc_cnt <= CycW'(1);
            end else if (state == WAIT_ACK || state == RUN) begin
                cyc_cnt <= cyc_next;
            end
            if (state == RUN && ita_idle_i && !abort_i) begin
                head_cycles <= cyc_next;
            end
        end
    end
`else
    assign head_cycles_o = '0;
`endif
endmodule

// File: tb/tb_ita_head_scheduler.sv
// tb_ita_head_scheduler: randomized jobs against a behavioural ITA and an event-time model
// of the scheduler (pulse, head-done, done, busy and error cycles computed arithmetically).
module tb_ita_head_scheduler;
    localparam int HeadW = 4;
    localparam int AckTimeout = 16;
    localparam int CycW = 24;
`ifdef ITA_HEAD_PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic start_i = 1'b0;
    logic abort_i = 1'b0;
    logic ita_idle_i = 1'b1;
    logic [HeadW-1:0] num_heads_i = '0;
    logic ita_start_o, head_done_o, done_o, busy_o, err_o;
    logic [HeadW-1:0] head_idx_o;
    logic [CycW-1:0] head_cycles_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pulse = -1;
    int busy_rise = -1;
    int busy_fall = -1;
    int err_rise = -1;
    bit busy_q = 1'b0;
    bit err_q = 1'b0;
    bit err_m = 1'b0;
    int ack_a[16];
    int run_a[16];
    int pulse_q[$], pidx_q[$], hd_q[$], hc_q[$], done_q[$];

    ita_head_scheduler #(.HeadW(HeadW), .AckTimeout(AckTimeout), .CycW(CycW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .num_heads_i(num_heads_i), .ita_idle_i(ita_idle_i), .ita_start_o(ita_start_o),
        .head_idx_o(head_idx_o), .head_done_o(head_done_o), .done_o(done_o),
        .busy_o(busy_o), .err_o(err_o), .head_cycles_o(head_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // observe one cycle of outputs, then drive the ITA idle line for that cycle
    task automatic step();
        int k;
        @(negedge clk);
        cyc++;
        if (ita_start_o) begin
            pulse_q.push_back(cyc);
            pidx_q.push_back(int'(head_idx_o));
            last_pulse = cyc;
        end
        if (head_done_o) begin
            hd_q.push_back(cyc);
            hc_q.push_back(int'(head_cycles_o));
        end
        if (done_o) done_q.push_back(cyc);
        if (busy_o && !busy_q && busy_rise < 0) busy_rise = cyc;
        if (!busy_o && busy_q && busy_fall < 0) busy_fall = cyc;
        if (err_o && !err_q && err_rise < 0) err_rise = cyc;
        busy_q = busy_o;
        err_q = err_o;
        k = (pulse_q.size() > 0) ? pulse_q.size() - 1 : 0;
        ita_idle_i = !(last_pulse >= 0 && cyc >= last_pulse + ack_a[k] &&
                       cyc < last_pulse + ack_a[k] + run_a[k]);
    endtask

    // mode: 0 normal, 1 ack timeout on head tgt, 2 abort at completion of head tgt,
    // 3 one-cycle reset during head tgt
    task automatic run_job(input int nh, input int mode, input int tgt, input bit fixed);
        int t0, evt, stop, n_p, n_hd, d;
        int p[16], hdc[16];
        pulse_q.delete(); pidx_q.delete(); hd_q.delete(); hc_q.delete(); done_q.delete();
        last_pulse = -1; busy_rise = -1; busy_fall = -1; err_rise = -1;
        for (int k = 0; k < 16; k++) begin
            ack_a[k] = fixed ? 1 : $urandom_range(1, 3);
            run_a[k] = fixed ? 10 : $urandom_range(1, 12);
        end
        if (mode == 1) ack_a[tgt] = 1000;
        t0 = cyc;
        for (int k = 0; k < 16; k++) begin
            p[k] = (k == 0) ? t0 + 1 : hdc[k-1];
            hdc[k] = p[k] + ack_a[k] + run_a[k] + 1;
        end
        d = (nh == 0) ? t0 + 1 : hdc[nh-1];
        case (mode)
            1: evt = p[tgt] + AckTimeout + 1;
            2: evt = hdc[tgt];
            3: evt = p[tgt] + 2;
            default: evt = (nh == 0) ? t0 + 1 : d + 1;
        endcase
        n_p = (mode == 0) ? nh : tgt + 1;
        n_hd = (mode == 0) ? nh : tgt;
        start_i = 1'b1;
        num_heads_i = HeadW'(nh);
        stop = evt + 4;
        while (cyc < stop) begin
            step();
            start_i = busy_o ? 1'($urandom) : 1'b0;
            num_heads_i = HeadW'($urandom);
            abort_i = (mode == 2 && cyc == evt - 1);
            rst_ni = !(mode == 3 && cyc == evt - 1);
            if (mode == 3 && cyc == evt)
                check("rst_outputs", {ita_start_o, head_idx_o, head_done_o, done_o, busy_o,
                                      err_o, head_cycles_o}, 0);
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        rst_ni = 1'b1;
        if (mode == 1) err_m = 1'b1;
        else if (mode == 3 || nh > 0) err_m = 1'b0;
        check("n_pulse", pulse_q.size(), n_p);
        for (int k = 0; k < n_p && k < pulse_q.size(); k++) begin
            check("pulse_cycle", pulse_q[k] - t0, p[k] - t0);
            check("pulse_idx", pidx_q[k], k);
        end
        check("n_head_done", hd_q.size(), n_hd);
        for (int k = 0; k < n_hd && k < hd_q.size(); k++) begin
            check("head_done_cycle", hd_q[k] - t0, hdc[k] - t0);
            check("head_cycles", hc_q[k], Perf ? ack_a[k] + run_a[k] + 1 : 0);
        end
        check("n_done", done_q.size(), (mode == 0) ? 1 : 0);
        if (mode == 0 && done_q.size() == 1) check("done_cycle", done_q[0] - t0, d - t0);
        check("busy_rise", (busy_rise < 0) ? -1 : busy_rise - t0, (nh == 0) ? -1 : 1);
        check("busy_fall", (busy_fall < 0) ? -1 : busy_fall - t0, (nh == 0) ? -1 : evt - t0);
        check("busy_end", busy_o, 0);
        check("err", err_o, err_m);
        if (mode == 1) check("err_rise", err_rise - t0, evt - t0);
    endtask

    initial begin
        int nh, mode;
        for (int k = 0; k < 16; k++) begin
            ack_a[k] = 1;
            run_a[k] = 1;
        end
        repeat (2) step();
        rst_ni = 1'b1;
        step();
        check("reset_state", {ita_start_o, head_idx_o, head_done_o, done_o, busy_o,
                              err_o, head_cycles_o}, 0);
        run_job(3, 0, 0, 1'b1);
        run_job(0, 0, 0, 1'b0);
        run_job(2, 1, 0, 1'b0);
        run_job(0, 0, 0, 1'b0);
        run_job(4, 2, 1, 1'b0);
        run_job(4, 3, 2, 1'b0);
        run_job(1, 0, 0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            nh = $urandom_range(1, 6);
            mode = $urandom_range(0, 3);
            run_job(nh, mode, $urandom_range(0, nh - 1), 1'b0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ita_head_scheduler.md
ITA_HEAD_SCHEDULER -- requirements
Module: ita_head_scheduler

Interface
REQ-001 SHALL have parameter HeadW, default 4: width of head count and head index.
REQ-002 SHALL have parameter AckTimeout, default 16: max cycles awaiting ITA acknowledge after a start pulse.
REQ-003 SHALL have parameter CycW, default 24: width of the per-head cycle counter.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start_i  input  1  request to run a multi-head attention job.
REQ-007 SHALL have port abort_i  input  1  cancel the running job.
REQ-008 SHALL have port num_heads_i  input  HeadW  number of heads in the job, sampled with start_i.
REQ-009 SHALL have port ita_idle_i  input  1  high while the ITA controller step is Idle.
REQ-010 SHALL have port ita_start_o  output  1  one-cycle start pulse to the ITA controller.
REQ-011 SHALL have port head_idx_o  output  HeadW  index of the head being processed.
REQ-012 SHALL have port head_done_o  output  1  one-cycle pulse per completed head.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse at job completion.
REQ-014 SHALL have port busy_o  output  1  high from job acceptance until done, abort or error.
REQ-015 SHALL have port err_o  output  1  sticky acknowledge-timeout flag.
REQ-016 SHALL have port head_cycles_o  output  CycW  cycle count of the last completed head.

Function
REQ-017 SHALL implement states IDLE, START, WAIT_ACK, RUN, FINISH; every output SHALL be registered or decoded from the state register only.
REQ-018 SHALL, in IDLE with start_i=1 and num_heads_i>0, latch num_heads_i, clear head_idx_o and err_o, set busy_o, and enter START next cycle.
REQ-019 SHALL, in IDLE with start_i=1 and num_heads_i=0, pulse done_o in the next cycle, keep busy_o low and stay in IDLE.
REQ-020 SHALL drive ita_start_o=1 for exactly the one cycle spent in START, then enter WAIT_ACK.
REQ-021 SHALL, in WAIT_ACK, enter RUN on the first cycle with ita_idle_i=0 and clear the ack-timeout counter.
REQ-022 SHALL, in WAIT_ACK, set err_o, clear busy_o and return to IDLE when AckTimeout cycles pass without ita_idle_i=0.
REQ-023 SHALL, in RUN, on ita_idle_i=1, pulse head_done_o for one cycle; if head_idx_o equals latched count-1, enter FINISH, else increment head_idx_o and enter START.
REQ-024 SHALL, in FINISH, pulse done_o for one cycle, clear busy_o, and enter IDLE; head_idx_o SHALL hold the last index until the next start.
REQ-025 SHALL ignore start_i in every state except IDLE.
REQ-026 SHALL, on abort_i=1 in any non-IDLE state, enter IDLE next cycle with busy_o=0, no done_o, no head_done_o and no further ita_start_o; abort_i SHALL take priority over all other transitions.
REQ-027 SHALL give abort_i priority over a same-cycle ita_idle_i completion in RUN, so head_done_o is suppressed.
REQ-028 SHALL produce exactly num_heads ita_start_o pulses per uninterrupted job, with a minimum gap of 2 cycles between consecutive pulses.

Reset
REQ-029 SHALL, on clk_i edge with rst_ni=0, enter IDLE and clear ita_start_o, head_idx_o, head_done_o, done_o, busy_o, err_o, head_cycles_o and all internal counters, also mid-job.

Configuration
REQ-030 SHALL, with macro ITA_HEAD_PERF_CNT_EN defined, count cycles from the ita_start_o cycle to the ita_idle_i=1 cycle inclusive, saturating at all-ones, and load head_cycles_o with the count together with head_done_o.
REQ-031 SHALL, without ITA_HEAD_PERF_CNT_EN, contain no cycle counter and tie head_cycles_o to zero.

Verification
REQ-032 SHALL cover: num_heads_i=3, ITA acks 1 cycle after each pulse, runs 10 cycles -> 3 ita_start_o pulses, head_done_o with head_idx_o 0,1,2, one done_o, busy_o low after FINISH.
REQ-033 SHALL cover: num_heads_i=0 with start_i -> done_o one cycle later, no ita_start_o, busy_o stays 0.
REQ-034 SHALL cover: ita_idle_i held 1 after the pulse for 16 cycles -> err_o=1, busy_o=0, state IDLE, no done_o.
REQ-035 SHALL cover: abort_i during RUN of head 1 of 4, coincident with ita_idle_i rising -> no head_done_o, no done_o, no further ita_start_o, busy_o=0 next cycle.
REQ-036 SHALL cover: rst_ni low for one cycle mid-job at head 2 -> all outputs zero the next cycle; start_i while busy is ignored.
REQ-037 SHALL cover: with ITA_HEAD_PERF_CNT_EN, head running 1 ack cycle + 10 busy cycles -> head_cycles_o=12; without the macro -> head_cycles_o=0.
